ttl_mux_scanner: RTL and testbench
==================================

TTL_MUX_SCANNER -- requirements
Module: ttl_mux_scanner

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent mux channels.
REQ-002 Parameter INPUTS, default 4: inputs per channel; SHALL be a power of two, 2 or more.
REQ-003 Parameter WIDTH, default 1: bits per input.
REQ-004 Derived constant SEL_W = clog2(INPUTS).
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 mode  input  2  operating mode: 00 HOLD, 01 DIRECT, 10 SCAN_UP, 11 SCAN_DOWN.
REQ-008 sel_in  input  SEL_W  select value used in DIRECT mode.
REQ-009 enable_n  input  CHANNELS  per-channel enable, active low (1 forces that channel's output to zero).
REQ-010 data_in  input  CHANNELS*INPUTS*WIDTH  flattened inputs; channel c, input i occupies bits [(c*INPUTS+i)*WIDTH +: WIDTH].
REQ-011 y  output  CHANNELS*WIDTH  registered outputs; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-012 sel_out  output  SEL_W  current select register.
REQ-013 valid  output  1  registered; high when y was updated on the last edge.
REQ-014 wrap  output  1  registered one-cycle pulse on select wrap-around in either scan mode.

Function
REQ-015 The block SHALL hold a select register sel of SEL_W bits; sel_out SHALL equal sel.
REQ-016 The next value of sel SHALL depend on mode:
- HOLD: sel unchanged.
- DIRECT: sel becomes sel_in.
- SCAN_UP: sel becomes (sel+1) mod INPUTS.
- SCAN_DOWN: sel becomes (sel-1) mod INPUTS.
REQ-017 In any mode other than HOLD, each channel c SHALL load y_c on the edge: zero if enable_n[c] is 1, otherwise data_in input sel of channel c. The current sel value (before update) SHALL be used, giving one-cycle latency.
REQ-018 In HOLD mode, y SHALL retain its value regardless of data_in and enable_n.
REQ-019 valid SHALL be registered as (mode != HOLD) on every edge.
REQ-020 wrap SHALL be registered as 1 on an edge where:
- mode is SCAN_UP and sel = INPUTS-1, or
- mode is SCAN_DOWN and sel = 0.
Otherwise wrap SHALL be registered as 0. DIRECT loads SHALL never assert wrap.
REQ-021 A mode change takes effect on the first edge where the new mode is sampled; there is no extra pipeline delay.
REQ-022 An enable_n change SHALL affect only its own channel and only on edges not in HOLD.
REQ-023 All arithmetic on sel SHALL be SEL_W-bit modulo; no out-of-range select is possible.

Reset
REQ-024 While reset is high, the following SHALL be zero asynchronously and held at zero: sel, y, valid, wrap.
REQ-025 On the first edge after reset deasserts, normal mode behaviour SHALL resume from sel = 0.
REQ-026 Reset asserted mid-scan SHALL discard the scan position. There is no retained state.

Structure
REQ-027 Package ttl_mux_pkg SHALL hold the mode encodings (MODE_HOLD, MODE_DIRECT, MODE_SCAN_UP, MODE_SCAN_DOWN) as named 2-bit constants.
REQ-028 Sub-module ttl_sel_counter (parameter SEL_W) SHALL implement the sel register and wrap logic. The top level SHALL instantiate it once and generate the CHANNELS output registers.

Verification
REQ-029 Reset while in SCAN_UP with sel = 2 -> immediately sel_out = 0, y = 0, valid = 0, wrap = 0.
REQ-030 Defaults, SCAN_UP for 5 cycles from sel = 0 -> sel_out sequence 1,2,3,0,1. wrap is high only in the cycle after the edge where sel = 3. y_0 follows inputs 0,1,2,3,0 with one-cycle latency.
REQ-031 SCAN_DOWN from sel = 0 -> sel_out = 3 and wrap = 1 on the first edge, then sel_out = 2 and wrap = 0 on the next.
REQ-032 DIRECT with sel_in = 2, data_in channel 1 input 2 = 1, enable_n = 2'b00 -> after edge 1 sel_out = 2; after edge 2 y[1] = 1 and valid = 1. With enable_n[1] = 1 instead, y[1] = 0 after edge 2.
REQ-033 HOLD after y = 2'b11, then toggle all data_in and enable_n -> y stays 2'b11, sel_out unchanged, valid = 0.
REQ-034 CHANNELS = 3, INPUTS = 8, WIDTH = 4, DIRECT with sel_in = 7, input 7 of channel c = c+5 -> y = {4'd7, 4'd6, 4'd5} two edges later.

Source files
------------

// File: rtl/ttl_mux_pkg.sv
// ttl_mux_pkg: mode encodings shared by the mux scanner and its select counter
package ttl_mux_pkg;
    localparam logic [1:0] MODE_HOLD      = 2'b00;
    localparam logic [1:0] MODE_DIRECT    = 2'b01;
    localparam logic [1:0] MODE_SCAN_UP   = 2'b10;
    localparam logic [1:0] MODE_SCAN_DOWN = 2'b11;
endpackage

// File: rtl/ttl_sel_counter.sv
// ttl_sel_counter: select register with direct load, up/down scan and wrap pulse
module ttl_sel_counter
    import ttl_mux_pkg::*;
#(
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel_in,
    output logic [SEL_W-1:0] sel,
    output logic             wrap
);
    logic [SEL_W-1:0] sel_nxt;
    logic             wrap_nxt;
    // SEL_W-bit wraparound gives mod INPUTS because INPUTS is a power of two
    always_comb begin
        sel_nxt  = mode == MODE_DIRECT    ? sel_in :
                   mode == MODE_SCAN_UP   ? sel + 1'b1 :
                   mode == MODE_SCAN_DOWN ? sel - 1'b1 : sel;
        wrap_nxt = (mode == MODE_SCAN_UP && &sel) || (mode == MODE_SCAN_DOWN && sel == '0);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel  <= '0;
            wrap <= 1'b0;
        end else begin
            sel  <= sel_nxt;
            wrap <= wrap_nxt;
        end
    end
endmodule

// File: rtl/ttl_mux_scanner.sv
// ttl_mux_scanner: multi-channel registered mux driven by a shared scanning select
module ttl_mux_scanner
    import ttl_mux_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int INPUTS   = 4,
    parameter int WIDTH    = 1,
    localparam int SEL_W   = $clog2(INPUTS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   mode,
    input  logic [SEL_W-1:0]             sel_in,
    input  logic [CHANNELS-1:0]          enable_n,
    input  logic [CHANNELS*INPUTS*WIDTH-1:0] data_in,
    output logic [CHANNELS*WIDTH-1:0]    y,
    output logic [SEL_W-1:0]             sel_out,
    output logic                         valid,
    output logic                         wrap
);
    ttl_sel_counter #(.SEL_W(SEL_W)) u_sel (
        .clk    (clk),
        .reset  (reset),
        .mode   (mode),
        .sel_in (sel_in),
        .sel    (sel_out),
        .wrap   (wrap)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) valid <= 1'b0;
        else valid <= mode != MODE_HOLD;
    end
    // each channel samples with the pre-update select, giving one cycle of latency
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [INPUTS-1:0][WIDTH-1:0] ch_data;
        logic [WIDTH-1:0]             y_r;
        assign ch_data = data_in[c*INPUTS*WIDTH +: INPUTS*WIDTH];
        assign y[c*WIDTH +: WIDTH] = y_r;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) y_r <= '0;
            else if (mode != MODE_HOLD) y_r <= enable_n[c] ? '0 : ch_data[sel_out];
        end
    end
endmodule

// File: tb/tb_ttl_mux_scanner.sv
// tb_ttl_mux_scanner: randomized and directed checks of two scanner configurations against a behavioural model
module tb_ttl_mux_scanner;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic [1:0]  sel_in_a = '0;
    logic [1:0]  en_a = '0;
    logic [7:0]  data_a = '0;
    logic [1:0]  y_a, sel_a;
    logic        valid_a, wrap_a;
    logic [2:0]  sel_in_b = '0;
    logic [2:0]  en_b = '0;
    logic [95:0] data_b = '0;
    logic [11:0] y_b;
    logic [2:0]  sel_b;
    logic        valid_b, wrap_b;
    int checks = 0, failures = 0;
    int ma_sel = 0, ma_valid = 0, ma_wrap = 0;
    int mb_sel = 0, mb_valid = 0, mb_wrap = 0;
    logic [1:0]  ma_y = '0;
    logic [11:0] mb_y = '0;

    always #5 clk = ~clk;

    ttl_mux_scanner dut_a (
        .clk(clk), .reset(reset), .mode(mode), .sel_in(sel_in_a), .enable_n(en_a),
        .data_in(data_a), .y(y_a), .sel_out(sel_a), .valid(valid_a), .wrap(wrap_a)
    );
    ttl_mux_scanner #(.CHANNELS(3), .INPUTS(8), .WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .mode(mode), .sel_in(sel_in_b), .enable_n(en_b),
        .data_in(data_b), .y(y_b), .sel_out(sel_b), .valid(valid_b), .wrap(wrap_b)
    );

    function automatic int next_sel(int m, int s, int si, int n);
        return m == 1 ? si : m == 2 ? (s + 1) % n : m == 3 ? (s + n - 1) % n : s;
    endfunction

    task automatic model_reset();
        ma_sel = 0; ma_valid = 0; ma_wrap = 0; ma_y = '0;
        mb_sel = 0; mb_valid = 0; mb_wrap = 0; mb_y = '0;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else begin
            if (mode != 2'b00) begin
                for (int c = 0; c < 2; c++) ma_y[c] = en_a[c] ? 1'b0 : data_a[c*4 + ma_sel];
                for (int c = 0; c < 3; c++) mb_y[c*4 +: 4] = en_b[c] ? 4'd0 : data_b[(c*8 + mb_sel)*4 +: 4];
            end
            ma_valid = int'(mode != 2'b00);
            mb_valid = ma_valid;
            ma_wrap = int'((mode == 2'b10 && ma_sel == 3) || (mode == 2'b11 && ma_sel == 0));
            mb_wrap = int'((mode == 2'b10 && mb_sel == 7) || (mode == 2'b11 && mb_sel == 0));
            ma_sel = next_sel(int'(mode), ma_sel, int'(sel_in_a), 4);
            mb_sel = next_sel(int'(mode), mb_sel, int'(sel_in_b), 8);
        end
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks += 4;
        if (sel_a !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel_a); end
        if (y_a !== 2'd0) begin failures++; $display("FAIL reset_y got=%0h exp=0", y_a); end
        if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid_a); end
        if (wrap_a !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%0b exp=0", wrap_a); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        mode = 2'b10;
        data_a = 8'hff;
        step();
        step();
        checks++;
        if (sel_a !== 2'd2) begin failures++; $display("FAIL midscan_pre_sel got=%0d exp=2", sel_a); end
        reset = 1'b1;
        #1;
        model_reset();
        checks += 4;
        if (sel_a !== 2'd0) begin failures++; $display("FAIL midscan_sel got=%0d exp=0", sel_a); end
        if (y_a !== 2'd0) begin failures++; $display("FAIL midscan_y got=%0h exp=0", y_a); end
        if (valid_a !== 1'b0) begin failures++; $display("FAIL midscan_valid got=%0b exp=0", valid_a); end
        if (wrap_a !== 1'b0) begin failures++; $display("FAIL midscan_wrap got=%0b exp=0", wrap_a); end
        mode = 2'b00;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_scan_up();
        int exp_sel[5] = '{1, 2, 3, 0, 1};
        int exp_wrap[5] = '{0, 0, 0, 1, 0};
        data_a = 8'($urandom);
        en_a = 2'b00;
        mode = 2'b10;
        for (int i = 0; i < 5; i++) begin
            step();
            checks += 3;
            if (sel_a !== 2'(exp_sel[i])) begin failures++; $display("FAIL scan_up_sel[%0d] got=%0d exp=%0d", i, sel_a, exp_sel[i]); end
            if (wrap_a !== 1'(exp_wrap[i])) begin failures++; $display("FAIL scan_up_wrap[%0d] got=%0b exp=%0d", i, wrap_a, exp_wrap[i]); end
            if (y_a[0] !== data_a[(exp_sel[i] + 3) % 4]) begin failures++; $display("FAIL scan_up_y0[%0d] got=%0b exp=%0b", i, y_a[0], data_a[(exp_sel[i] + 3) % 4]); end
        end
    endtask

    task automatic test_scan_down();
        mode = 2'b01;
        sel_in_a = 2'd0;
        step();
        mode = 2'b11;
        step();
        checks += 2;
        if (sel_a !== 2'd3) begin failures++; $display("FAIL scan_down_sel0 got=%0d exp=3", sel_a); end
        if (wrap_a !== 1'b1) begin failures++; $display("FAIL scan_down_wrap0 got=%0b exp=1", wrap_a); end
        step();
        checks += 2;
        if (sel_a !== 2'd2) begin failures++; $display("FAIL scan_down_sel1 got=%0d exp=2", sel_a); end
        if (wrap_a !== 1'b0) begin failures++; $display("FAIL scan_down_wrap1 got=%0b exp=0", wrap_a); end
    endtask

    task automatic test_direct();
        mode = 2'b01;
        sel_in_a = 2'd2;
        data_a = 8'b0100_0000;
        en_a = 2'b00;
        step();
        checks += 2;
        if (sel_a !== 2'd2) begin failures++; $display("FAIL direct_sel got=%0d exp=2", sel_a); end
        if (wrap_a !== 1'b0) begin failures++; $display("FAIL direct_wrap got=%0b exp=0", wrap_a); end
        step();
        checks += 2;
        if (y_a[1] !== 1'b1) begin failures++; $display("FAIL direct_y1 got=%0b exp=1", y_a[1]); end
        if (valid_a !== 1'b1) begin failures++; $display("FAIL direct_valid got=%0b exp=1", valid_a); end
        en_a = 2'b10;
        step();
        checks++;
        if (y_a[1] !== 1'b0) begin failures++; $display("FAIL direct_disabled_y1 got=%0b exp=0", y_a[1]); end
    endtask

    task automatic test_hold();
        logic [1:0] held_sel;
        mode = 2'b01;
        sel_in_a = 2'd1;
        data_a = 8'hff;
        en_a = 2'b00;
        step();
        step();
        held_sel = sel_a;
        mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            data_a = ~data_a;
            en_a = ~en_a;
            step();
            checks += 3;
            if (y_a !== 2'b11) begin failures++; $display("FAIL hold_y[%0d] got=%0h exp=3", i, y_a); end
            if (sel_a !== held_sel) begin failures++; $display("FAIL hold_sel[%0d] got=%0d exp=%0d", i, sel_a, held_sel); end
            if (valid_a !== 1'b0) begin failures++; $display("FAIL hold_valid[%0d] got=%0b exp=0", i, valid_a); end
        end
    endtask

    task automatic test_wide();
        mode = 2'b01;
        sel_in_b = 3'd7;
        en_b = 3'b000;
        data_b = 96'($urandom);
        for (int c = 0; c < 3; c++) data_b[(c*8 + 7)*4 +: 4] = 4'(c + 5);
        step();
        checks++;
        if (sel_b !== 3'd7) begin failures++; $display("FAIL wide_sel got=%0d exp=7", sel_b); end
        step();
        checks++;
        if (y_b !== 12'h765) begin failures++; $display("FAIL wide_y got=%0h exp=765", y_b); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            mode = 2'($urandom);
            sel_in_a = 2'($urandom);
            sel_in_b = 3'($urandom);
            en_a = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            en_b = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            data_a = 8'($urandom);
            data_b = {32'($urandom), 32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                @(negedge clk);
                reset = 1'b0;
            end
            step();
            checks += 8;
            if (sel_a !== 2'(ma_sel)) begin failures++; $display("FAIL rnd_sel_a[%0d] got=%0d exp=%0d", i, sel_a, ma_sel); end
            if (y_a !== ma_y) begin failures++; $display("FAIL rnd_y_a[%0d] got=%0h exp=%0h", i, y_a, ma_y); end
            if (valid_a !== 1'(ma_valid)) begin failures++; $display("FAIL rnd_valid_a[%0d] got=%0b exp=%0d", i, valid_a, ma_valid); end
            if (wrap_a !== 1'(ma_wrap)) begin failures++; $display("FAIL rnd_wrap_a[%0d] got=%0b exp=%0d", i, wrap_a, ma_wrap); end
            if (sel_b !== 3'(mb_sel)) begin failures++; $display("FAIL rnd_sel_b[%0d] got=%0d exp=%0d", i, sel_b, mb_sel); end
            if (y_b !== mb_y) begin failures++; $display("FAIL rnd_y_b[%0d] got=%0h exp=%0h", i, y_b, mb_y); end
            if (valid_b !== 1'(mb_valid)) begin failures++; $display("FAIL rnd_valid_b[%0d] got=%0b exp=%0d", i, valid_b, mb_valid); end
            if (wrap_b !== 1'(mb_wrap)) begin failures++; $display("FAIL rnd_wrap_b[%0d] got=%0b exp=%0d", i, wrap_b, mb_wrap); end
        end
    endtask

    initial begin
        test_reset();
        test_scan_up();
        test_scan_down();
        test_direct();
        test_hold();
        test_wide();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
